mem_access_unit: RTL

- Load/store unit between the EX/MEM pipeline register and the 256x32 data memory (DataMem).
- Converts byte-addressed byte/half/word requests into word-granular DataMem accesses.
- Sub-word stores are done as read-modify-write. Loads are sign- or zero-extended. Misaligned requests are flagged.
- Holds off the pipeline through `busy` while an access is in flight.

---
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM register and the 256x32 DataMem.
// Latency (edges after accept to resp_valid): load 2, word store 2, sub-word store 4, error 0.
// Backpressure: busy is high whenever the FSM is not IDLE; req_* are ignored while busy.
//
// Ports:
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   req_*                : byte-addressed request (we, size, unsigned, addr, wdata)
//   busy                 : combinational, state != IDLE
//   resp_valid/err/rdata : one-cycle completion pulse, error flag, extended load data
//   dm_*                 : word-granular DataMem interface (registered read data, write-done)
module mem_access_unit #(
    parameter int ADDR_W     = 10,
    parameter int WD_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [7:0]        dm_addr,
    output logic [31:0]       dm_data_in,
    output logic              dm_we,
    input  logic [31:0]       dm_data_out,
    input  logic              dm_wd
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ISSUE   = 3'd1,
        RD_CAPTURE = 3'd2,
        WR_ISSUE   = 3'd3,
        WR_ACK     = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(WD_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [1:0]         off_q, off_d;
    logic [7:0]         idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        merge_q, merge_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q, resp_err_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;

    logic               misaligned;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        ld_ext;
    logic [31:0]        merged;

    // Alignment check on the incoming request (size 11 is never legal).
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Lane extraction/extension for loads and lane replacement for sub-word stores,
    // both working on the registered DataMem word seen in RD_CAPTURE.
    always_comb begin
        byte_sel = dm_data_out[8*off_q +: 8];
        half_sel = dm_data_out[16*off_q[1] +: 16];
        ld_ext   = dm_data_out;
        merged   = dm_data_out;
        case (size_q)
            2'b00: begin
                ld_ext = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                merged[8*off_q +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                ld_ext = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                merged[16*off_q[1] +: 16] = wdata_q[15:0];
            end
            default: begin
                ld_ext = dm_data_out;
                merged = dm_data_out;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        // Rejected without touching DataMem; request registers keep
                        // their old contents so dm_addr does not move.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        we_d    = req_we;
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        off_d   = req_addr[1:0];
                        idx_d   = req_addr[ADDR_W-1:2];
                        wdata_d = req_wdata;
                        state_d = (req_we && req_size == 2'b10) ? WR_ISSUE : RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                state_d = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                if (we_q) begin
                    merge_d = merged;
                    state_d = WR_ISSUE;
                end else begin
                    resp_rdata_d = ld_ext;
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            WR_ISSUE: begin
                cnt_d   = '0;
                state_d = WR_ACK;
            end
            WR_ACK: begin
                if (dm_wd) begin
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end else if (cnt_q == CNT_W'(WD_TIMEOUT - 1)) begin
                    // Last allowed WR_ACK cycle without write-done.
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            idx_q        <= 8'h00;
            wdata_q      <= 32'h0;
            merge_q      <= 32'h0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // dm_we decodes straight from state, so an async reset kills a pending write
    // before the next edge can commit it.
    assign busy       = (state_q != IDLE);
    assign dm_we      = (state_q == WR_ISSUE);
    assign dm_addr    = idx_q;
    assign dm_data_in = (size_q == 2'b10) ? wdata_q : merge_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule
